// File: rtl/program_loader_if.sv
// Byte-stream input and memory write port of the program loader, bundled.
// The master side is the loader itself; the slave side is the environment
// (byte source plus processor memory port).
interface program_loader_if #(
  parameter int word_size = 8
);
  logic                 in_valid;
  logic [word_size-1:0] in_data;
  logic                 in_ready;
  logic                 ext_write;
  logic [word_size-1:0] address_bus;
  logic [word_size-1:0] data_bus;

  modport master (
    input  in_valid,
    input  in_data,
    output in_ready,
    output ext_write,
    output address_bus,
    output data_bus
  );

  modport slave (
    output in_valid,
    output in_data,
    input  in_ready,
    input  ext_write,
    input  address_bus,
    input  data_bus
  );
endinterface

// File: rtl/program_loader.sv
// Program loader: receives LEN, BASE, N data bytes and a checksum byte,
// writes the data into processor memory, then releases the core on a good
// checksum or flags an error on a bad one.
module program_loader #(
  parameter int word_size = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  program_loader_if.master  bus,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_BASE,
    S_DATA,
    S_CSUM,
    S_RUN,
    S_ERR
  } state_t;

  state_t               state_q, state_d;
  logic [word_size-1:0] count_q, count_d;
  logic [word_size-1:0] ptr_q, ptr_d;
  logic [word_size-1:0] sum_q, sum_d;
  logic                 ext_write_q, ext_write_d;
  logic [word_size-1:0] addr_q, addr_d;
  logic [word_size-1:0] data_q, data_d;
  logic                 loading;
  logic                 accept;

  // Loading states are the only ones that take bytes or honour abort.
  always_comb begin
    loading = (state_q == S_LEN) || (state_q == S_BASE) ||
              (state_q == S_DATA) || (state_q == S_CSUM);
    accept  = loading && bus.in_valid;
  end

  // Next-state, counter, pointer, checksum and write-port computation.
  // count holds the bytes still expected; LEN = 0 wraps through all values
  // so a full 2**word_size bytes are taken before the last-byte test hits 1.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    ptr_d       = ptr_q;
    sum_d       = sum_q;
    ext_write_d = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LEN;
      end
      S_LEN: begin
        if (accept) begin
          count_d = bus.in_data;
          state_d = S_BASE;
        end
      end
      S_BASE: begin
        if (accept) begin
          ptr_d   = bus.in_data;
          sum_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          ext_write_d = 1'b1;
          addr_d      = ptr_q;
          data_d      = bus.in_data;
          ptr_d       = ptr_q + word_size'(1);
          sum_d       = sum_q + bus.in_data;
          count_d     = count_q - word_size'(1);
          if (count_q == word_size'(1)) state_d = S_CSUM;
        end
      end
      S_CSUM: begin
        if (accept) state_d = (bus.in_data == sum_q) ? S_RUN : S_ERR;
      end
      S_RUN, S_ERR: begin
        if (start) state_d = S_LEN;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort && loading) state_d = S_IDLE;
  end

  // State and datapath registers, cleared asynchronously by rst low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      ptr_q       <= '0;
      sum_q       <= '0;
      ext_write_q <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      ptr_q       <= ptr_d;
      sum_q       <= sum_d;
      ext_write_q <= ext_write_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
    end
  end

  // Status outputs decode directly from the current state.
  always_comb begin
    bus.in_ready    = loading;
    bus.ext_write   = ext_write_q;
    bus.address_bus = addr_q;
    bus.data_bus    = data_q;
    cpu_rst         = (state_q == S_RUN);
    done            = (state_q == S_RUN);
    err             = (state_q == S_ERR);
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: expected memory writes are queued
// as data bytes are driven and checked when the write strobe appears.
module tb_program_loader;

  logic clk;
  logic rst;
  logic start;
  logic abort;
  logic cpu_rst;
  logic done;
  logic err;

  int nCompared;
  int nMismatch;

  logic [15:0] sbQueue[$];
  logic [7:0]  imgData[$];

  program_loader_if #(.word_size(8)) bus ();

  program_loader #(.word_size(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .abort   (abort),
    .bus     (bus),
    .cpu_rst (cpu_rst),
    .done    (done),
    .err     (err)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, wanted finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatch++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every strobe must match the oldest queued write.
  always @(negedge clk) begin
    if (rst && bus.ext_write) begin
      if (sbQueue.size() == 0) begin
        checkOutput("spurious_wr", {31'd0, bus.ext_write}, 32'd0);
      end else begin
        logic [15:0] expWr;
        expWr = sbQueue.pop_front();
        checkOutput("wr_addr", {24'd0, bus.address_bus}, {24'd0, expWr[15:8]});
        checkOutput("wr_data", {24'd0, bus.data_bus}, {24'd0, expWr[7:0]});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one byte for exactly one clock edge.
  task automatic applyStimulus(input logic [7:0] b);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    tick();
    bus.in_valid = 1'b0;
    bus.in_data  = 8'hEE;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic checkStatus(input string tag, input logic rdy, input logic cpu,
                             input logic dn, input logic er);
    checkOutput({tag, "_ready"}, {31'd0, bus.in_ready}, {31'd0, rdy});
    checkOutput({tag, "_cpu_rst"}, {31'd0, cpu_rst}, {31'd0, cpu});
    checkOutput({tag, "_done"}, {31'd0, done}, {31'd0, dn});
    checkOutput({tag, "_err"}, {31'd0, err}, {31'd0, er});
  endtask

  // Start a session and stream LEN, BASE, the first nData bytes of imgData
  // (optionally with an idle cycle after each) and optionally the checksum.
  task automatic loadImage(input logic [7:0] len, input logic [7:0] base,
                           input int nData, input bit gap,
                           input bit sendCsum, input logic [7:0] csum);
    logic [7:0] a;
    pulseStart();
    applyStimulus(len);
    applyStimulus(base);
    for (int i = 0; i < nData; i++) begin
      a = base + i[7:0];
      sbQueue.push_back({a, imgData[i]});
      applyStimulus(imgData[i]);
      if (gap) tick();
    end
    if (sendCsum) applyStimulus(csum);
  endtask

  task automatic drainCheck(input string tag);
    tick();
    checkOutput({tag, "_sb_left"}, sbQueue.size(), 32'd0);
  endtask

  initial begin
    nCompared    = 0;
    nMismatch    = 0;
    rst          = 1'b0;
    start        = 1'b0;
    abort        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    // Reset state
    #12;
    checkStatus("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_wr", {31'd0, bus.ext_write}, 32'd0);
    checkOutput("rst_addr", {24'd0, bus.address_bus}, 32'd0);
    checkOutput("rst_data", {24'd0, bus.data_bus}, 32'd0);
    rst = 1'b1;
    bus.in_valid = 1'b1;
    tick();
    tick();
    bus.in_valid = 1'b0;
    checkStatus("idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Basic three-byte image
    imgData = '{8'hAA, 8'hBB, 8'hCC};
    loadImage(8'h03, 8'h10, 3, 1'b0, 1'b1, 8'h31);
    checkStatus("basic", 1'b0, 1'b1, 1'b1, 1'b0);
    drainCheck("basic");
    checkOutput("hold_addr", {24'd0, bus.address_bus}, 32'h12);
    checkOutput("hold_data", {24'd0, bus.data_bus}, 32'hCC);

    // Address wrap, started straight from RUN
    imgData = '{8'h01, 8'h02};
    pulseStart();
    checkStatus("rerun", 1'b1, 1'b0, 1'b0, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    loadImage(8'h02, 8'hFF, 2, 1'b0, 1'b1, 8'h03);
    checkStatus("wrap", 1'b0, 1'b1, 1'b1, 1'b0);
    drainCheck("wrap");

    // Checksum error, then restart clears err
    imgData = '{8'h55};
    loadImage(8'h01, 8'h00, 1, 1'b0, 1'b1, 8'h54);
    checkStatus("cserr", 1'b0, 1'b0, 1'b0, 1'b1);
    drainCheck("cserr");
    pulseStart();
    checkStatus("errclr", 1'b1, 1'b0, 1'b0, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkStatus("abort_len", 1'b0, 1'b0, 1'b0, 1'b0);

    // Gapped stream: a write only for each accepted byte
    imgData = '{8'h11, 8'h22, 8'h33};
    loadImage(8'h03, 8'h20, 3, 1'b1, 1'b1, 8'h66);
    checkStatus("gap", 1'b0, 1'b1, 1'b1, 1'b0);
    drainCheck("gap");

    // Full-depth image: LEN = 0 means 256 data bytes
    imgData.delete();
    for (int i = 0; i < 256; i++) imgData.push_back(i[7:0]);
    loadImage(8'h00, 8'h00, 256, 1'b0, 1'b1, 8'h80);
    checkStatus("full", 1'b0, 1'b1, 1'b1, 1'b0);
    drainCheck("full");

    // Abort after two of four data bytes
    imgData = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    loadImage(8'h04, 8'h40, 2, 1'b0, 1'b0, 8'h00);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkStatus("abort", 1'b0, 1'b0, 1'b0, 1'b0);
    drainCheck("abort");

    // start+abort together: start wins in IDLE, abort wins in LEN
    start = 1'b1;
    abort = 1'b1;
    tick();
    checkStatus("both_idle", 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    start = 1'b0;
    abort = 1'b0;
    checkStatus("both_len", 1'b0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-session after the second data byte
    imgData = '{8'h01, 8'h02, 8'h03, 8'h04};
    loadImage(8'h04, 8'h50, 2, 1'b0, 1'b0, 8'h00);
    tick();
    rst = 1'b0;
    #1;
    checkStatus("midrst", 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("midrst_wr", {31'd0, bus.ext_write}, 32'd0);
    checkOutput("midrst_addr", {24'd0, bus.address_bus}, 32'd0);
    checkOutput("midrst_data", {24'd0, bus.data_bus}, 32'd0);
    #10;
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h04;
    tick();
    tick();
    tick();
    bus.in_valid = 1'b0;
    checkStatus("postrst", 1'b0, 1'b0, 1'b0, 1'b0);
    drainCheck("postrst");
    pulseStart();
    checkStatus("postrst_start", 1'b1, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter word_size, default 8, sets data and address width; memory depth is 2**word_size.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle request to begin a load session.
REQ-005 abort  input  1  one-cycle request to cancel a load session in progress.
REQ-006 in_valid  input  1  byte-stream source has a byte on in_data.
REQ-007 in_data  input  word_size  byte-stream payload.
REQ-008 in_ready  output  1  loader can accept a byte this cycle.
REQ-009 ext_write  output  1  memory write strobe to the processor memory port.
REQ-010 address_bus  output  word_size  memory write address.
REQ-011 data_bus  output  word_size  memory write data.
REQ-012 cpu_rst  output  1  active-low reset to the processor core; low holds the core in reset.
REQ-013 done  output  1  image loaded and verified; core released.
REQ-014 err  output  1  checksum mismatch on the last session.

Function
REQ-015 A byte transfers only on a rising edge where in_valid and in_ready are both 1.
REQ-016 Stream format: LEN byte, then BASE byte, then N data bytes, then CSUM byte. N = LEN, except LEN = 0 means N = 2**word_size.
REQ-017 States: IDLE, LEN, BASE, DATA, CSUM, RUN, ERR. in_ready = 1 only in LEN, BASE, DATA and CSUM.
REQ-018 IDLE: start -> LEN. in_valid is ignored.
REQ-019 LEN: an accepted byte is stored as the count -> BASE.
REQ-020 BASE: an accepted byte loads the address pointer and clears the running sum -> DATA.
REQ-021 DATA, per accepted byte:
  - next cycle: ext_write = 1 for exactly one cycle; data_bus = byte; address_bus = pointer.
  - then pointer += 1 mod 2**word_size (0xFF wraps to 0x00).
  - sum += byte mod 2**word_size.
  - after the Nth byte -> CSUM.
REQ-022 ext_write is 0 in every cycle other than those defined in REQ-021. Back-to-back accepted bytes produce back-to-back write cycles at consecutive addresses.
REQ-023 CSUM: if the accepted byte equals sum -> RUN; otherwise -> ERR.
REQ-024 cpu_rst = 1 only in RUN and 0 in every other state. done = 1 only in RUN. err = 1 only in ERR.
REQ-025 start in RUN or ERR -> LEN. cpu_rst drops to 0 and done/err clear on the same edge.
REQ-026 start in LEN, BASE, DATA or CSUM is ignored.
REQ-027 abort in LEN, BASE, DATA or CSUM -> IDLE. Memory writes already issued are not undone. A pending ext_write from a byte accepted on the abort edge still issues.
REQ-028 If start and abort are asserted together, abort wins in a loading state and start wins in IDLE, RUN or ERR.
REQ-029 address_bus and data_bus hold their last written values between writes.

Reset
REQ-030 While rst = 0, and on its assertion at any time including mid-session:
  - state = IDLE.
  - in_ready, ext_write, cpu_rst, done and err = 0.
  - address_bus, data_bus, count, pointer and sum = 0.
REQ-031 After rst deasserts, the loader stays in IDLE until start.

Verification
REQ-032 start; stream 03,10,AA,BB,CC,31 with in_valid held high -> three consecutive writes (10:AA, 11:BB, 12:CC); then done = 1, cpu_rst = 1, err = 0.
REQ-033 LEN=02, BASE=FF, data 01,02, CSUM=03 -> writes FF:01, 00:02 (address wrap); then done = 1.
REQ-034 LEN=01, BASE=00, data 55, CSUM=54 -> one write 00:55; then err = 1, cpu_rst = 0, done = 0. Next start returns to LEN and clears err.
REQ-035 in_valid toggled 1/0 every cycle during DATA -> writes occur only after accepted bytes; no duplicate or missing addresses; final sum is correct.
REQ-036 rst pulsed low after the second data byte of a 4-byte image -> all outputs go to 0 immediately; in_ready stays 0 until start.
REQ-037 abort during DATA of LEN=04 after two bytes -> exactly two writes; IDLE; cpu_rst = 0, done = 0, err = 0.
